game_state_engine: RTL and testbench

Per-frame Breakout game-state engine sitting directly upstream of the game renderer. On each frame-done strobe it runs a short multi-cycle update: moves the paddle from button inputs, advances the ball one axis at a time, resolves wall/paddle/block collisions, and sequences serve/play/lost/won states. Its registered outputs (paddle X, ball X/Y, 72-bit block state) feed the renderer directly; they change only during the update burst.

---
 rtl/game_state_engine.sv | 204 ++++++++++++++++++++
 tb/tb_game_state_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_engine.sv
// game_state_engine: per-frame Breakout update. A FRAME_DONE strobe kicks a
// seven-state burst that moves the paddle, steps the ball one axis at a time,
// resolves wall/paddle/block hits and then advances the game state. Outputs
// are plain registers so the renderer only ever sees whole-frame results.
module game_state_engine #(
   parameter int BALL_STEP   = 2,
   parameter int PADDLE_STEP = 4,
   parameter int LOST_DELAY  = 60
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FRAME_DONE,
   input  logic        BTN_LEFT,
   input  logic        BTN_RIGHT,
   input  logic        BTN_LAUNCH,
   output logic [9:0]  PADDLE_X_PIXEL,
   output logic [9:0]  BALL_X_PIXEL,
   output logic [9:0]  BALL_Y_PIXEL,
   output logic [71:0] BLOCK_STATE,
   output logic [1:0]  LIVES,
   output logic [2:0]  GAME_STATE
);
   localparam int CNT_W = (LOST_DELAY > 1) ? $clog2(LOST_DELAY) : 1;
   localparam logic signed [10:0] BSTEP = 11'(BALL_STEP);
   localparam logic signed [10:0] PSTEP = 11'(PADDLE_STEP);
   localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_DELAY - 1);

   typedef enum logic [2:0] {
      UPD_IDLE, UPD_PADDLE, UPD_BALL_X, UPD_HIT_X, UPD_BALL_Y, UPD_HIT_Y, UPD_STATUS
   } updState_t;

   typedef enum logic [2:0] {
      GS_SERVE = 3'd0, GS_PLAY = 3'd1, GS_LOST = 3'd2, GS_GAME_OVER = 3'd3, GS_WON = 3'd4
   } gameState_t;

   updState_t        updState, updNext;
   gameState_t       gameSt, gameNext;
   logic [9:0]       paddleX, paddleNext, ballX, ballXNext, ballY, ballYNext;
   logic             dxNeg, dxNegNext, dyNeg, dyNegNext;
   logic [71:0]      blocks, blocksNext;
   logic [1:0]       lives, livesNext;
   logic [CNT_W-1:0] lostCnt, lostCntNext;

   logic signed [10:0] padS, bxS, byS, colOff, rowOff;
   logic signed [10:0] stepX, stepY, padMove;
   logic [6:0]         blkIdx;
   logic               blkHit;

   assign padS = {1'b0, paddleX};
   assign bxS  = {1'b0, ballX};
   assign byS  = {1'b0, ballY};

   // Block under the ball centre: offset of centre (x+4,y+4) from the grid origin (16,64)
   always_comb begin
      colOff = bxS - 11'sd12;
      rowOff = byS - 11'sd60;
      blkIdx = 7'(rowOff >>> 4) * 7'd12 + 7'(colOff >>> 6);
      blkHit = (colOff >= 11'sd0) && (colOff < 11'sd768) &&
               (rowOff >= 11'sd0) && (rowOff < 11'sd96) && blocks[blkIdx];
   end

   // Update sequencer state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) updState <= UPD_IDLE;
      else       updState <= updNext;
   end

   // Update sequencer: one pass per frame, strobes during a pass are dropped
   always_comb begin
      updNext = updState;
      case (updState)
         UPD_IDLE:   if (FRAME_DONE) updNext = UPD_PADDLE;
         UPD_PADDLE: updNext = UPD_BALL_X;
         UPD_BALL_X: updNext = UPD_HIT_X;
         UPD_HIT_X:  updNext = UPD_BALL_Y;
         UPD_BALL_Y: updNext = UPD_HIT_Y;
         UPD_HIT_Y:  updNext = UPD_STATUS;
         default:    updNext = UPD_IDLE;
      endcase
   end

   // Game state registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         gameSt  <= GS_SERVE;
         paddleX <= 10'd368;
         ballX   <= 10'd396;
         ballY   <= 10'd552;
         dxNeg   <= 1'b0;
         dyNeg   <= 1'b1;
         blocks  <= '1;
         lives   <= 2'd3;
         lostCnt <= '0;
      end else begin
         gameSt  <= gameNext;
         paddleX <= paddleNext;
         ballX   <= ballXNext;
         ballY   <= ballYNext;
         dxNeg   <= dxNegNext;
         dyNeg   <= dyNegNext;
         blocks  <= blocksNext;
         lives   <= livesNext;
         lostCnt <= lostCntNext;
      end
   end

   // Per-step game update; each sequencer state touches only its own fields
   always_comb begin
      gameNext    = gameSt;
      paddleNext  = paddleX;
      ballXNext   = ballX;
      ballYNext   = ballY;
      dxNegNext   = dxNeg;
      dyNegNext   = dyNeg;
      blocksNext  = blocks;
      livesNext   = lives;
      lostCntNext = lostCnt;
      padMove     = padS;
      stepX       = dxNeg ? -BSTEP : BSTEP;
      stepY       = dyNeg ? -BSTEP : BSTEP;
      case (updState)
         UPD_PADDLE: begin
            if (BTN_LEFT && !BTN_RIGHT) begin
               padMove    = padS - PSTEP;
               paddleNext = (padMove < 11'sd8) ? 10'd8 : 10'(padMove);
            end else if (BTN_RIGHT && !BTN_LEFT) begin
               padMove    = padS + PSTEP;
               paddleNext = (padMove > 11'sd728) ? 10'd728 : 10'(padMove);
            end
         end
         UPD_BALL_X: if (gameSt == GS_PLAY) ballXNext = 10'(bxS + stepX);
         UPD_HIT_X: if (gameSt == GS_PLAY) begin
            if (bxS < 11'sd8) begin
               ballXNext = 10'd8;
               dxNegNext = 1'b0;
            end else if (bxS > 11'sd784) begin
               ballXNext = 10'd784;
               dxNegNext = 1'b1;
            end else if (blkHit) begin
               blocksNext[blkIdx] = 1'b0;
               dxNegNext          = !dxNeg;
               ballXNext          = 10'(bxS - stepX);
            end
         end
         UPD_BALL_Y: if (gameSt == GS_PLAY) ballYNext = 10'(byS + stepY);
         UPD_HIT_Y: if (gameSt == GS_PLAY) begin
            if (byS < 11'sd8) begin
               ballYNext = 10'd8;
               dyNegNext = 1'b0;
            end else if (!dyNeg && (byS + 11'sd7 >= 11'sd560) && (byS + 11'sd7 <= 11'sd567) &&
                         (bxS + 11'sd7 >= padS) && (bxS <= padS + 11'sd63)) begin
               ballYNext = 10'd552;
               dyNegNext = 1'b1;
            end else if (blkHit) begin
               blocksNext[blkIdx] = 1'b0;
               dyNegNext          = !dyNeg;
               ballYNext          = 10'(byS - stepY);
            end
         end
         UPD_STATUS: begin
            case (gameSt)
               GS_SERVE: begin
                  ballXNext = paddleX + 10'd28;
                  ballYNext = 10'd552;
                  if (BTN_LAUNCH) begin
                     gameNext  = GS_PLAY;
                     dxNegNext = 1'b0;
                     dyNegNext = 1'b1;
                  end
               end
               GS_PLAY: begin
                  if (byS >= 11'sd600) begin
                     gameNext    = GS_LOST;
                     livesNext   = lives - 2'd1;
                     lostCntNext = '0;
                  end else if (blocks == '0) begin
                     gameNext = GS_WON;
                  end
               end
               GS_LOST: begin
                  if (lostCnt == LOST_LAST) gameNext = (lives == 2'd0) ? GS_GAME_OVER : GS_SERVE;
                  else                      lostCntNext = lostCnt + 1'b1;
               end
               GS_GAME_OVER, GS_WON: begin
                  if (BTN_LAUNCH) begin
                     blocksNext = '1;
                     livesNext  = 2'd3;
                     gameNext   = GS_SERVE;
                  end
               end
               default: gameNext = GS_SERVE;
            endcase
         end
         default: ;
      endcase
   end

   assign PADDLE_X_PIXEL = paddleX;
   assign BALL_X_PIXEL   = ballX;
   assign BALL_Y_PIXEL   = ballY;
   assign BLOCK_STATE    = blocks;
   assign LIVES          = lives;
   assign GAME_STATE     = gameSt;
endmodule

// File: tb/tb_game_state_engine.sv
// tb_game_state_engine: table vectors, hand sequences and random frames,
// all checked against a frame-level model of the game rules.
module tb_game_state_engine;
   localparam int S_SERVE = 0, S_PLAY = 1, S_LOST = 2, S_OVER = 3;

   logic        CLK = 1'b0;
   logic        RESET, FRAME_DONE, BTN_LEFT, BTN_RIGHT, BTN_LAUNCH;
   logic [9:0]  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
   logic [71:0] BLOCK_STATE;
   logic [1:0]  LIVES;
   logic [2:0]  GAME_STATE;

   game_state_engine dut (
      .CLK(CLK), .RESET(RESET), .FRAME_DONE(FRAME_DONE),
      .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT), .BTN_LAUNCH(BTN_LAUNCH),
      .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL),
      .BALL_Y_PIXEL(BALL_Y_PIXEL), .BLOCK_STATE(BLOCK_STATE),
      .LIVES(LIVES), .GAME_STATE(GAME_STATE)
   );

   always #5 CLK = ~CLK;

   int passCnt = 0;
   int totalCnt = 0;

   // frame-level model of the game
   int          mPad, mBx, mBy, mDx, mDy, mLives, mState, mLost;
   logic [71:0] mBlocks;

   typedef struct {
      bit l; bit r; bit la; int frames;
      int pad; int bx; int by; int st; int lives;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic checkOuts(input string name, input int pad, input int bx, input int by,
                            input int st, input int lv);
      check(name, {PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, GAME_STATE, LIVES},
            {10'(pad), 10'(bx), 10'(by), 3'(st), 2'(lv)});
   endtask

   task automatic modelReset();
      mPad = 368; mBx = 396; mBy = 552; mDx = 1; mDy = -1;
      mBlocks = '1; mLives = 3; mState = S_SERVE; mLost = 0;
   endtask

   function automatic int blockAt(input int cx, input int cy);
      if (cx < 16 || cx >= 784 || cy < 64 || cy >= 160) return -1;
      return ((cy - 64) / 16) * 12 + (cx - 16) / 64;
   endfunction

   task automatic modelFrame(input bit l, input bit r, input bit la);
      int idx;
      if (l && !r)      mPad = (mPad - 4 < 8) ? 8 : mPad - 4;
      else if (r && !l) mPad = (mPad + 4 > 728) ? 728 : mPad + 4;
      if (mState == S_PLAY) begin
         mBx += 2 * mDx;
         if (mBx < 8) begin mBx = 8; mDx = 1; end
         else if (mBx > 784) begin mBx = 784; mDx = -1; end
         else begin
            idx = blockAt(mBx + 4, mBy + 4);
            if (idx >= 0 && mBlocks[idx]) begin
               mBlocks[idx] = 1'b0; mBx -= 2 * mDx; mDx = -mDx;
            end
         end
         mBy += 2 * mDy;
         if (mBy < 8) begin mBy = 8; mDy = 1; end
         else if (mDy == 1 && mBy + 7 >= 560 && mBy + 7 <= 567 &&
                  mBx + 7 >= mPad && mBx <= mPad + 63) begin
            mBy = 552; mDy = -1;
         end else begin
            idx = blockAt(mBx + 4, mBy + 4);
            if (idx >= 0 && mBlocks[idx]) begin
               mBlocks[idx] = 1'b0; mBy -= 2 * mDy; mDy = -mDy;
            end
         end
      end
      case (mState)
         S_SERVE: begin
            mBx = mPad + 28; mBy = 552;
            if (la) begin mState = S_PLAY; mDx = 1; mDy = -1; end
         end
         S_PLAY: begin
            if (mBy >= 600) begin mState = S_LOST; mLives--; mLost = 0; end
            else if (mBlocks == '0) mState = 4;
         end
         S_LOST: begin
            mLost++;
            if (mLost == 60) mState = (mLives == 0) ? S_OVER : S_SERVE;
         end
         default: if (la) begin mBlocks = '1; mLives = 3; mState = S_SERVE; end
      endcase
   endtask

   task automatic cmpModel(input string name);
      checkOuts(name, mPad, mBx, mBy, mState, mLives);
      check({name, "Blocks"}, BLOCK_STATE, mBlocks);
   endtask

   // one full frame: strobe, let the burst finish, step the model, compare
   task automatic frame(input bit l, input bit r, input bit la, input string name);
      @(negedge CLK);
      BTN_LEFT = l; BTN_RIGHT = r; BTN_LAUNCH = la; FRAME_DONE = 1'b1;
      @(negedge CLK);
      FRAME_DONE = 1'b0;
      repeat (8) @(negedge CLK);
      modelFrame(l, r, la);
      cmpModel(name);
   endtask

   function automatic int predictLand(input int x, input int dx, input int y);
      while (y < 554) begin
         x += 2 * dx;
         if (x < 8) begin x = 8; dx = 1; end
         else if (x > 784) begin x = 784; dx = -1; end
         y += 2;
      end
      return x;
   endfunction

   // steer the paddle to the far side from where a falling ball will land
   task automatic evade(output bit l, output bit r);
      int land, target;
      l = 1'b0; r = 1'b0;
      if (mDy > 0) begin
         land   = predictLand(mBx, mDx, mBy);
         target = (land + 4 < 400) ? 728 : 8;
         if (mPad < target) r = 1'b1;
         else if (mPad > target) l = 1'b1;
      end
   endtask

   initial begin
      int  f, yHit, maxBx, prevBx, padBefore;
      bit  sawWall, l, r;
      RESET = 1'b1; FRAME_DONE = 1'b0;
      BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_LAUNCH = 1'b0;
      vecs[0] = '{0, 0, 0, 10,  368, 396, 552, S_SERVE, 3};
      vecs[1] = '{1, 0, 0, 100, 8,   36,  552, S_SERVE, 3};
      vecs[2] = '{0, 1, 0, 20,  88,  116, 552, S_SERVE, 3};
      vecs[3] = '{1, 1, 0, 5,   88,  116, 552, S_SERVE, 3};
      vecs[4] = '{0, 1, 0, 70,  368, 396, 552, S_SERVE, 3};

      repeat (3) @(negedge CLK);
      checkOuts("resetState", 368, 396, 552, S_SERVE, 3);
      check("resetBlocks", BLOCK_STATE, {72{1'b1}});
      RESET = 1'b0;
      modelReset();

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < vecs[i].frames; k++) frame(vecs[i].l, vecs[i].r, vecs[i].la, "tableTrack");
         checkOuts($sformatf("vec%0d", i), vecs[i].pad, vecs[i].bx, vecs[i].by, vecs[i].st, vecs[i].lives);
      end

      // launch, climb to the first block, bounce off the right wall on the way
      frame(0, 0, 1, "launch");
      checkOuts("launchFrame", 368, 396, 552, S_PLAY, 3);
      frame(0, 0, 0, "firstMove");
      checkOuts("firstMove", 368, 398, 550, S_PLAY, 3);
      maxBx = 0; prevBx = -1; sawWall = 1'b0;
      for (f = 0; f < 400 && BLOCK_STATE === {72{1'b1}}; f++) begin
         frame(0, 0, 0, "toBlock");
         if (int'(BALL_X_PIXEL) > maxBx) maxBx = int'(BALL_X_PIXEL);
         if (prevBx == 784 && BALL_X_PIXEL == 10'd784) sawWall = 1'b1;
         prevBx = int'(BALL_X_PIXEL);
      end
      check("oneBlockCleared", $countones(BLOCK_STATE), 71);
      check("wallClampX", maxBx, 784);
      check("wallHold", sawWall, 1);
      yHit = mBy;
      frame(0, 0, 0, "afterBlock");
      check("dyAfterBlock", BALL_Y_PIXEL, 10'(yHit + 2));

      // lose all three lives with the paddle kept away from the ball
      for (int life = 0; life < 3; life++) begin
         for (f = 0; f < 3000 && mState != S_LOST; f++) begin
            if (mState == S_SERVE) frame(0, 0, 1, "serve");
            else begin evade(l, r); frame(l, r, 0, "evade"); end
         end
         check("lostEntry", {GAME_STATE, LIVES}, {3'(S_LOST), 2'(2 - life)});
         repeat (59) frame(0, 0, 0, "lostWait");
         check("stillLost", GAME_STATE, S_LOST);
         frame(0, 0, 0, "lostEnd");
         check("afterLost", GAME_STATE, (life < 2) ? S_SERVE : S_OVER);
      end
      frame(0, 0, 1, "restore");
      check("restoreLives", LIVES, 3);
      check("restoreBlocks", BLOCK_STATE, {72{1'b1}});
      check("restoreState", GAME_STATE, S_SERVE);

      // second strobe 3 cycles into the burst must be ignored
      repeat (20) frame(1, 0, 0, "preDouble");
      padBefore = mPad;
      @(negedge CLK);
      BTN_LEFT = 1'b0; BTN_RIGHT = 1'b1; BTN_LAUNCH = 1'b0; FRAME_DONE = 1'b1;
      @(negedge CLK); FRAME_DONE = 1'b0;
      @(negedge CLK);
      @(negedge CLK); FRAME_DONE = 1'b1;
      @(negedge CLK); FRAME_DONE = 1'b0;
      repeat (8) @(negedge CLK);
      modelFrame(0, 1, 0);
      cmpModel("doublePulse");
      check("doublePulsePad", PADDLE_X_PIXEL, 10'(padBefore + 4));

      for (int i = 0; i < 1500; i++)
         frame(1'($urandom % 2), 1'($urandom % 2), ($urandom % 8) == 0, "random");

      // reset asserted while the burst sits in the x-collision step
      @(negedge CLK);
      BTN_LEFT = 1'b0; BTN_RIGHT = 1'b1; BTN_LAUNCH = 1'b0; FRAME_DONE = 1'b1;
      @(negedge CLK); FRAME_DONE = 1'b0;
      @(negedge CLK);
      @(negedge CLK); RESET = 1'b1;
      #1;
      checkOuts("resetAsync", 368, 396, 552, S_SERVE, 3);
      check("resetAsyncBlocks", BLOCK_STATE, {72{1'b1}});
      @(negedge CLK);
      checkOuts("resetHeld", 368, 396, 552, S_SERVE, 3);
      RESET = 1'b0; BTN_RIGHT = 1'b0;
      modelReset();
      frame(0, 0, 0, "postReset");
      checkOuts("postResetFrame", 368, 396, 552, S_SERVE, 3);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
